// File: rtl/tt_mohan_pkg.sv
// Shared pin map, constants and state type for the Mohan 8/8 sequential divider.
package tt_mohan_pkg;

   localparam int unsigned OP_W  = 8;
   localparam int unsigned CNT_W = $clog2(OP_W);

   localparam logic [7:0] UIO_OE = 8'b1110_0000;

   // uio_in control bits
   localparam int unsigned LOAD_DIVIDEND_BIT = 0;
   localparam int unsigned LOAD_DIVISOR_BIT  = 1;
   localparam int unsigned START_BIT         = 2;
   localparam int unsigned SEL_REM_BIT       = 3;

   // uio_out status bits
   localparam int unsigned DIV_BY_ZERO_BIT   = 5;
   localparam int unsigned BUSY_BIT          = 6;
   localparam int unsigned DONE_BIT          = 7;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } div_state_e;

endpackage

// File: rtl/mohan_div_core.sv
// Restoring divider datapath: one quotient bit per enabled cycle, MSB first,
// with the IDLE/RUN/DONE control and the bit counter.
module mohan_div_core
   import tt_mohan_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ena_i,
   input  logic            start_i,
   input  logic            load_i,
   input  logic [OP_W-1:0] dividend_i,
   input  logic [OP_W-1:0] divisor_i,
   output logic [OP_W-1:0] quotient_o,
   output logic [OP_W-1:0] remainder_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            div_by_zero_o
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]  quo_q, quo_d;
   logic [OP_W-1:0]  rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [OP_W:0]    rem_shift;
   logic             fits;

   // cnt runs 0..OP_W-1, so the MSB-first dividend bit index OP_W-1-cnt is ~cnt.
   assign rem_shift = {rem_q, dividend_i[~cnt_q]};
   assign fits      = rem_shift >= {1'b0, divisor_i};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               cnt_d = '0;
               if (divisor_i == '0) begin
                  state_d = StDone;
                  quo_d   = '1;
                  rem_d   = dividend_i;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = StRun;
                  quo_d   = '0;
                  rem_d   = '0;
                  dbz_d   = 1'b0;
               end
            end else if (load_i) begin
               // Results stay visible; only the status is dropped.
               state_d = StIdle;
               dbz_d   = 1'b0;
            end
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            quo_d = {quo_q[OP_W-2:0], fits};
            rem_d = fits ? rem_shift[OP_W-1:0] - divisor_i : rem_shift[OP_W-1:0];
            if (cnt_q == CNT_W'(OP_W - 1)) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else if (ena_i) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient_o    = quo_q;
   assign remainder_o   = rem_q;
   assign busy_o        = (state_q == StRun);
   assign done_o        = (state_q == StDone);
   assign div_by_zero_o = dbz_q;

endmodule

// File: rtl/tt_um_mohan_divider.sv
// Tiny Tapeout wrapper for the 8/8 sequential divider: pin decode, operand
// registers and the quotient/remainder output mux.
module tt_um_mohan_divider
   import tt_mohan_pkg::*;
(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   logic [OP_W-1:0] dividend_q, dividend_d;
   logic [OP_W-1:0] divisor_q, divisor_d;
   logic [OP_W-1:0] quotient, remainder;
   logic            busy, done, div_by_zero;
   logic            ld_dividend, ld_divisor;
   logic            unused_uio;

   // Operands are frozen while a division is running.
   assign ld_dividend = uio_in[LOAD_DIVIDEND_BIT] & ~busy;
   assign ld_divisor  = uio_in[LOAD_DIVISOR_BIT] & ~busy;

   // The core sees the post-load values so a same-edge start uses fresh operands.
   assign dividend_d = ld_dividend ? ui_in : dividend_q;
   assign divisor_d  = ld_divisor ? ui_in : divisor_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dividend_q <= '0;
         divisor_q  <= '0;
      end else if (ena) begin
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
      end
   end

   mohan_div_core u_core (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .ena_i         (ena),
      .start_i       (uio_in[START_BIT]),
      .load_i        (ld_dividend | ld_divisor),
      .dividend_i    (dividend_d),
      .divisor_i     (divisor_d),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .busy_o        (busy),
      .done_o        (done),
      .div_by_zero_o (div_by_zero)
   );

   assign uo_out = uio_in[SEL_REM_BIT] ? remainder : quotient;

   always_comb begin
      uio_out                  = '0;
      uio_out[DONE_BIT]        = done;
      uio_out[BUSY_BIT]        = busy;
      uio_out[DIV_BY_ZERO_BIT] = div_by_zero;
   end

   assign uio_oe = UIO_OE;

   assign unused_uio = ^uio_in[7:4];

endmodule

// File: tb/tb_tt_um_mohan_divider.sv
// Randomized self-checking bench for tt_um_mohan_divider against an arithmetic
// reference (a / b, a % b) and edge-count timing expectations.
module tb_tt_um_mohan_divider;

   localparam logic [7:0] LD_DVD  = 8'h01;
   localparam logic [7:0] LD_DVS  = 8'h02;
   localparam logic [7:0] START   = 8'h04;
   localparam logic [7:0] SEL_REM = 8'h08;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   wire done = uio_out[7];
   wire busy = uio_out[6];
   wire dbz  = uio_out[5];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   tt_um_mohan_divider dut (
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_dividend(input logic [7:0] a);
      ui_in  = a;
      uio_in = LD_DVD;
      tick();
      uio_in = 8'h00;
   endtask

   // Runs one division and checks latency, busy span, status and results.
   task automatic divide(input logic [7:0] a, input logic [7:0] b, input int stall_at,
                         input int stall_n, input int inject_at, input bit fused);
      int edges, busy_cnt, exp_edges;
      logic [7:0] exp_q, exp_r;
      exp_q     = (b == 0) ? 8'hFF : a / b;
      exp_r     = (b == 0) ? a : a % b;
      exp_edges = (b == 0) ? 1 : 9 + stall_n;
      load_dividend(a);
      ui_in = b;
      if (fused) begin
         uio_in = LD_DVS | START;
      end else begin
         uio_in = LD_DVS;
         tick();
         uio_in = START;
      end
      tick();
      uio_in = 8'h00;
      edges  = 1;
      check($sformatf("busy_after_start %0d/%0d", a, b), busy, (b != 0));
      busy_cnt = 0;
      while (!done && edges < 40) begin
         ena = !(stall_n > 0 && edges >= stall_at && edges < stall_at + stall_n);
         if (busy && ena) busy_cnt++;
         if (edges == inject_at) begin
            ui_in  = 8'd1;
            uio_in = START | LD_DVS | LD_DVD;
         end else begin
            uio_in = 8'h00;
         end
         tick();
         edges++;
      end
      ena    = 1'b1;
      uio_in = 8'h00;
      check($sformatf("done_edge %0d/%0d", a, b), edges, exp_edges);
      check($sformatf("busy_cycles %0d/%0d", a, b), busy_cnt, (b == 0) ? 0 : 8);
      check($sformatf("dbz %0d/%0d", a, b), dbz, (b == 0));
      check($sformatf("quotient %0d/%0d", a, b), uo_out, exp_q);
      uio_in = SEL_REM;
      #1;
      check($sformatf("remainder %0d/%0d", a, b), uo_out, exp_r);
      uio_in = 8'h00;
      repeat (2) tick();
      check($sformatf("done_hold %0d/%0d", a, b), {done, busy}, 2'b10);
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      #2;
      check("reset_uo_out", uo_out, 0);
      check("reset_uio_out", uio_out, 0);
      check("reset_uio_oe", uio_oe, 8'hE0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_after_reset", uio_out, 0);

      divide(8'd100, 8'd7, 0, 0, 0, 1'b0);
      divide(8'd255, 8'd1, 0, 0, 0, 1'b0);
      divide(8'd3, 8'd10, 0, 0, 0, 1'b0);
      divide(8'd200, 8'd200, 0, 0, 0, 1'b0);
      divide(8'd5, 8'd0, 0, 0, 0, 1'b0);

      // Load in DONE drops status but keeps results.
      load_dividend(8'd9);
      check("load_in_done_status", uio_out, 0);
      check("load_in_done_result", uo_out, 8'hFF);

      divide(8'd100, 8'd7, 3, 3, 0, 1'b0);
      divide(8'd100, 8'd7, 0, 0, 4, 1'b0);
      divide(8'd100, 8'd7, 0, 0, 0, 1'b1);

      // Reset mid-run aborts with nothing visible.
      load_dividend(8'd100);
      ui_in  = 8'd7;
      uio_in = LD_DVS | START;
      tick();
      uio_in = 8'h00;
      repeat (4) tick();
      check("busy_before_reset", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrun_reset_quot", uo_out, 0);
      check("midrun_reset_status", uio_out, 0);
      uio_in = SEL_REM;
      #1;
      check("midrun_reset_rem", uo_out, 0);
      uio_in = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();
      check("post_reset_idle", uio_out, 0);
      check("post_reset_quot", uo_out, 0);

      for (int i = 0; i < 30; i++) begin
         logic [7:0] a, b;
         int sn;
         a  = 8'($urandom_range(0, 255));
         b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         sn = (b == 0) ? 0 : $urandom_range(0, 3);
         divide(a, b, $urandom_range(2, 8), sn, 0, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tt_um_mohan_divider.md
TT_UM_MOHAN_DIVIDER -- requirements
Module: tt_um_mohan_divider

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 8 bits by the pin budget.
REQ-002 clk  input  1  single clock for all state; rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  design-selected enable; all state SHALL hold while low.
REQ-005 ui_in  input  8  operand data bus, captured by load strobes.
REQ-006 uio_in  input  8  control: [0] load_dividend, [1] load_divisor, [2] start, [3] sel_rem; [7:4] ignored.
REQ-007 uo_out  output  8  quotient when sel_rem=0, remainder when sel_rem=1; combinational select of registered results.
REQ-008 uio_out  output  8  [7] done, [6] busy, [5] div_by_zero; [4:0] SHALL be driven 0.
REQ-009 uio_oe  output  8  SHALL be the constant 8'b1110_0000.

Function
REQ-010 The block SHALL be an unsigned 8/8 restoring sequential divider producing one quotient bit per enabled cycle.
REQ-011 States: IDLE, RUN, DONE; reset state IDLE.
REQ-012 With ena=1 in IDLE or DONE: load_dividend=1 SHALL capture ui_in into the dividend register, and load_divisor=1 SHALL capture ui_in into the divisor register; both on the same edge is legal.
REQ-013 A load in DONE SHALL clear done and div_by_zero and return to IDLE; results SHALL be retained.
REQ-014 start=1 sampled in IDLE or DONE with divisor!=0 SHALL enter RUN and clear done, div_by_zero, quotient and remainder.
REQ-015 If load and start are both asserted on the same edge, start SHALL use the newly loaded operands.
REQ-016 RUN SHALL last exactly 8 enabled cycles, MSB first: shift the partial remainder left and insert the next dividend bit; subtract the divisor; keep the difference and set the quotient bit if it is non-negative, otherwise restore.
REQ-017 After the 8th RUN cycle the block SHALL enter DONE. done SHALL be 1 on the 9th enabled edge after the start edge.
REQ-018 start=1 sampled with divisor=0 SHALL go directly to DONE on the next edge: quotient=8'hFF, remainder=dividend, div_by_zero=1.
REQ-019 busy SHALL be 1 exactly while in RUN, and done SHALL be 1 exactly while in DONE.
REQ-020 In RUN, start and load strobes SHALL be ignored and the operand registers SHALL be unchanged.
REQ-021 ena=0 SHALL freeze the state, the bit counter and all registers. Cycles with ena=0 SHALL NOT count toward the 8 RUN cycles.
REQ-022 done SHALL remain high until the next accepted start or load.

Reset
REQ-023 On rst_n=0 (asynchronous) the block SHALL clear state to IDLE and clear all registers, including the dividend, divisor, quotient, remainder and bit counter.
REQ-024 During reset: uo_out=0, uio_out=0, uio_oe=8'b1110_0000.
REQ-025 Reset asserted mid-RUN SHALL abort the division with no partial result visible.
REQ-026 Reset release SHALL take effect on the next rising edge; no operation SHALL start without a new start strobe.

Structure
REQ-027 A shared package tt_mohan_pkg SHALL hold:
- the state enum (IDLE/RUN/DONE);
- the UIO_OE constant;
- uio bit-index constants for load_dividend, load_divisor, start, sel_rem, done, busy and div_by_zero;
- the constant OP_W=8.
REQ-028 One sub-module, mohan_div_core, SHALL hold the datapath and the 3-bit counter with start/done ports. The top SHALL contain only pin decode, operand registers and the output mux.

Verification
REQ-029 Load dividend 100 and divisor 7, start -> busy for 8 cycles; done on the 9th edge; quotient 14 (sel_rem=0), remainder 2 (sel_rem=1).
REQ-030 Dividends 255/1 and 3/10 -> 255 r 0 and 0 r 3; 200/200 -> 1 r 0.
REQ-031 Dividend 5, divisor 0, start -> next edge done=1, div_by_zero=1, quotient 8'hFF, remainder 5, busy never 1.
REQ-032 Start 100/7 with ena low for 3 cycles mid-RUN -> done on the 12th edge, result still 14 r 2.
REQ-033 A start pulse and a divisor load of 1 at RUN cycle 4 -> both ignored; result 14 r 2.
REQ-034 Assert rst_n low at RUN cycle 5 -> all outputs 0 immediately; after release the state stays IDLE and done=0 until a new start.
